uart_word_rx: RTL

Parametrised UART receive front end for the FPU command path: oversampled start/bit/stop detection, optional parity, and assembly of WORD_BYTES characters into one operand word. Replaces the fixed 16-bit shift-register receiver with framing, parity, overrun and inter-character timeout checking. Output uses a valid/ready handshake toward the FPU control FSM. The oversample tick comes from the shared baud counter.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_char.sv | 203 ++++++++++++++++++++
 rtl/uart_word_rx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART word receiver: parity mode codes,
// receiver state encoding and the parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Expected parity bit for a zero-extended character; odd_sel inverts the XOR.
    function automatic logic calc_parity(input logic [8:0] data_bits, input logic odd_sel);
        return (^data_bits) ^ odd_sel;
    endfunction

endpackage

// File: rtl/uart_rx_char.sv
// Bit-level UART receiver: synchronises rx, finds the start bit, samples each
// bit at mid-period and reports one character (or one error) as a one-cycle strobe.
module uart_rx_char
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] char_data,
    output logic                 char_done,
    output logic                 char_frame_err,
    output logic                 char_parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam bit            PAR_EN    = (PARITY == PARITY_EVEN) || (PARITY == PARITY_ODD);
    localparam bit            PAR_ODD   = (PARITY == PARITY_ODD);

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    rx_state_t            state_r;
    rx_state_t            state_next_s;
    logic [TW-1:0]        tick_cnt_r;
    logic [TW-1:0]        tick_next_s;
    logic [3:0]           bit_cnt_r;
    logic [3:0]           bit_next_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;
    logic                 char_bad_r;
    logic                 bad_next_s;
    logic                 done_s;
    logic                 ferr_s;
    logic                 perr_s;
    logic [DATA_BITS-1:0] char_data_r;
    logic                 char_done_r;
    logic                 char_frame_err_r;
    logic                 char_parity_err_r;
    logic                 busy_r;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state, tick/bit counters, data shift and end-of-character strobes.
    always_comb begin
        state_next_s = state_r;
        tick_next_s  = tick_cnt_r;
        bit_next_s   = bit_cnt_r;
        shift_next_s = shift_r;
        bad_next_s   = char_bad_r;
        done_s       = 1'b0;
        ferr_s       = 1'b0;
        perr_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (baud_tick && !rx_sync_r) begin
                    state_next_s = ST_START;
                    tick_next_s  = TICK_ZERO;
                    bit_next_s   = 4'd0;
                    bad_next_s   = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (tick_cnt_r == HALF_LAST) begin
                        tick_next_s = TICK_ZERO;
                        // A high line at mid-start means the low level was a glitch.
                        if (!rx_sync_r) begin
                            state_next_s = ST_DATA;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end else begin
                        tick_next_s = tick_cnt_r + 1'b1;
                    end
                end else begin
                    tick_next_s = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_next_s  = TICK_ZERO;
                        shift_next_s = {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_next_s = 4'd0;
                            if (PAR_EN) begin
                                state_next_s = ST_PARITY;
                            end else begin
                                state_next_s = ST_STOP;
                            end
                        end else begin
                            bit_next_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        tick_next_s = tick_cnt_r + 1'b1;
                    end
                end else begin
                    tick_next_s = tick_cnt_r;
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_next_s  = TICK_ZERO;
                        state_next_s = ST_STOP;
                        if (rx_sync_r != calc_parity(9'(shift_r), PAR_ODD)) begin
                            bad_next_s = 1'b1;
                        end else begin
                            bad_next_s = char_bad_r;
                        end
                    end else begin
                        tick_next_s = tick_cnt_r + 1'b1;
                    end
                end else begin
                    tick_next_s = tick_cnt_r;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_next_s  = TICK_ZERO;
                        state_next_s = ST_IDLE;
                        // Framing error outranks a parity error on the same character.
                        if (!rx_sync_r) begin
                            ferr_s = 1'b1;
                        end else if (char_bad_r) begin
                            perr_s = 1'b1;
                        end else begin
                            done_s = 1'b1;
                        end
                    end else begin
                        tick_next_s = tick_cnt_r + 1'b1;
                    end
                end else begin
                    tick_next_s = tick_cnt_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                tick_next_s  = TICK_ZERO;
                bit_next_s   = 4'd0;
            end
        endcase
    end

    // State, counters and registered character strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            tick_cnt_r        <= TICK_ZERO;
            bit_cnt_r         <= 4'd0;
            shift_r           <= {DATA_BITS{1'b0}};
            char_bad_r        <= 1'b0;
            char_data_r       <= {DATA_BITS{1'b0}};
            char_done_r       <= 1'b0;
            char_frame_err_r  <= 1'b0;
            char_parity_err_r <= 1'b0;
            busy_r            <= 1'b0;
        end else begin
            state_r           <= state_next_s;
            tick_cnt_r        <= tick_next_s;
            bit_cnt_r         <= bit_next_s;
            shift_r           <= shift_next_s;
            char_bad_r        <= bad_next_s;
            char_done_r       <= done_s;
            char_frame_err_r  <= ferr_s;
            char_parity_err_r <= perr_s;
            busy_r            <= (state_next_s != ST_IDLE);
            if (done_s) begin
                char_data_r <= shift_r;
            end else begin
                char_data_r <= char_data_r;
            end
        end
    end

    assign char_data       = char_data_r;
    assign char_done       = char_done_r;
    assign char_frame_err  = char_frame_err_r;
    assign char_parity_err = char_parity_err_r;
    assign busy            = busy_r;

endmodule

// File: rtl/uart_word_rx.sv
// UART receive front end: gathers WORD_BYTES characters into one operand word
// and hands it over with valid/ready, flagging overrun and inter-character timeout.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int WORD_BYTES = 2,
    parameter int OVS        = 16,
    parameter int PARITY     = 0,
    parameter int MSB_FIRST  = 0,
    parameter int TIMEOUT    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            baud_tick,
    input  logic                            rx,
    output logic [WORD_BYTES*DATA_BITS-1:0] word_out,
    output logic                            word_valid,
    input  logic                            word_ready,
    output logic                            busy,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun_err,
    output logic                            timeout_err
);

    localparam int W     = WORD_BYTES * DATA_BITS;
    localparam int IDX_W = $clog2(WORD_BYTES + 1);
    localparam int TW    = $clog2(OVS);
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_BYTES - 1);
    localparam logic [TW-1:0]    TICK_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]    TICK_LAST = TW'(OVS - 1);
    localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT - 1);
    localparam bit               TO_EN     = (TIMEOUT > 0);

    logic [DATA_BITS-1:0] char_data_s;
    logic                 char_done_s;
    logic                 char_frame_err_s;
    logic                 char_parity_err_s;
    logic                 busy_s;

    logic [IDX_W-1:0] byte_idx_r;
    logic [IDX_W-1:0] idx_next_s;
    logic [IDX_W-1:0] slot_s;
    logic [W-1:0]     word_buf_r;
    logic [W-1:0]     buf_next_s;
    logic [W-1:0]     assembled_s;
    logic [W-1:0]     word_out_r;
    logic [W-1:0]     word_out_next_s;
    logic             word_valid_r;
    logic             valid_next_s;
    logic             overrun_s;
    logic             timeout_s;
    logic [TW-1:0]    idle_tick_r;
    logic [TW-1:0]    idle_tick_next_s;
    logic [15:0]      idle_bit_r;
    logic [15:0]      idle_bit_next_s;
    logic             to_hit_s;
    logic             frame_err_r;
    logic             parity_err_r;
    logic             overrun_err_r;
    logic             timeout_err_r;

    uart_rx_char #(
        .DATA_BITS (DATA_BITS),
        .OVS       (OVS),
        .PARITY    (PARITY)
    ) u_char (
        .clk             (clk),
        .rst             (rst),
        .baud_tick       (baud_tick),
        .rx              (rx),
        .char_data       (char_data_s),
        .char_done       (char_done_s),
        .char_frame_err  (char_frame_err_s),
        .char_parity_err (char_parity_err_s),
        .busy            (busy_s)
    );

    // Merge the incoming character into its slot of the partial word.
    always_comb begin
        assembled_s = word_buf_r;
        if (MSB_FIRST != 0) begin
            slot_s = IDX_LAST - byte_idx_r;
        end else begin
            slot_s = byte_idx_r;
        end
        assembled_s[int'(slot_s) * DATA_BITS +: DATA_BITS] = char_data_s;
    end

    // Idle-bit counter that aborts a stalled partial word.
    always_comb begin
        idle_tick_next_s = idle_tick_r;
        idle_bit_next_s  = idle_bit_r;
        to_hit_s         = 1'b0;
        if (!TO_EN || busy_s || (byte_idx_r == IDX_ZERO)) begin
            idle_tick_next_s = TICK_ZERO;
            idle_bit_next_s  = 16'd0;
        end else if (baud_tick) begin
            if (idle_tick_r == TICK_LAST) begin
                idle_tick_next_s = TICK_ZERO;
                idle_bit_next_s  = idle_bit_r + 16'd1;
                to_hit_s         = (idle_bit_r == TO_LAST);
            end else begin
                idle_tick_next_s = idle_tick_r + 1'b1;
            end
        end else begin
            idle_tick_next_s = idle_tick_r;
        end
    end

    // Word assembly, hand-off to the consumer and overrun/timeout decisions.
    always_comb begin
        idx_next_s      = byte_idx_r;
        buf_next_s      = word_buf_r;
        word_out_next_s = word_out_r;
        valid_next_s    = word_valid_r && !word_ready;
        overrun_s       = 1'b0;
        timeout_s       = 1'b0;
        if (char_done_s) begin
            if (byte_idx_r == IDX_LAST) begin
                idx_next_s = IDX_ZERO;
                // A pending word is only replaced if it is consumed this very cycle.
                if (!word_valid_r || word_ready) begin
                    word_out_next_s = assembled_s;
                    valid_next_s    = 1'b1;
                end else begin
                    overrun_s = 1'b1;
                end
            end else begin
                buf_next_s = assembled_s;
                idx_next_s = byte_idx_r + 1'b1;
            end
        end else if (char_frame_err_s || char_parity_err_s) begin
            idx_next_s = IDX_ZERO;
        end else if (to_hit_s) begin
            idx_next_s = IDX_ZERO;
            timeout_s  = 1'b1;
        end else begin
            idx_next_s = byte_idx_r;
        end
    end

    // Word-level registers and one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_r    <= IDX_ZERO;
            word_buf_r    <= {W{1'b0}};
            word_out_r    <= {W{1'b0}};
            word_valid_r  <= 1'b0;
            idle_tick_r   <= TICK_ZERO;
            idle_bit_r    <= 16'd0;
            frame_err_r   <= 1'b0;
            parity_err_r  <= 1'b0;
            overrun_err_r <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            byte_idx_r    <= idx_next_s;
            word_buf_r    <= buf_next_s;
            word_out_r    <= word_out_next_s;
            word_valid_r  <= valid_next_s;
            idle_tick_r   <= idle_tick_next_s;
            idle_bit_r    <= idle_bit_next_s;
            frame_err_r   <= char_frame_err_s;
            parity_err_r  <= char_parity_err_s;
            overrun_err_r <= overrun_s;
            timeout_err_r <= timeout_s;
        end
    end

    assign word_out    = word_out_r;
    assign word_valid  = word_valid_r;
    assign busy        = busy_s;
    assign frame_err   = frame_err_r;
    assign parity_err  = parity_err_r;
    assign overrun_err = overrun_err_r;
    assign timeout_err = timeout_err_r;

endmodule
